// File: rtl/adder_pkg.sv
// Constants shared by the adder and multiplier library.
package adder_pkg;

    localparam int unsigned ADDER_DEFAULT_WIDTH = 32;

endpackage : adder_pkg

// File: rtl/full_adder.sv
// Single-bit full adder; one stage of the ripple carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule : full_adder

// File: rtl/ripple_carry_adder.sv
// Two's-complement ripple-carry adder with carry-out, signed overflow flags and an
// optional output register stage.
module ripple_carry_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH   = ADDER_DEFAULT_WIDTH,
    parameter int unsigned REG_OUT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             posOverflow,
    output logic             negOverflow
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             pos_ovf_d;
    logic             neg_ovf_d;

    assign carry[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : gen_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (sum_d[i]),
            .cout (carry[i+1])
        );
    end

    assign cout_d = carry[WIDTH];

    // Overflow only when both operands share a sign and the sum's sign differs.
    assign pos_ovf_d = ~a[WIDTH-1] & ~b[WIDTH-1] & sum_d[WIDTH-1];
    assign neg_ovf_d = a[WIDTH-1] & b[WIDTH-1] & ~sum_d[WIDTH-1];

    if (REG_OUT != 0) begin : gen_reg_out
        logic [WIDTH-1:0] sum_q;
        logic             cout_q;
        logic             pos_ovf_q;
        logic             neg_ovf_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q     <= '0;
                cout_q    <= 1'b0;
                pos_ovf_q <= 1'b0;
                neg_ovf_q <= 1'b0;
            end else begin
                sum_q     <= sum_d;
                cout_q    <= cout_d;
                pos_ovf_q <= pos_ovf_d;
                neg_ovf_q <= neg_ovf_d;
            end
        end

        assign S           = sum_q;
        assign Cout        = cout_q;
        assign posOverflow = pos_ovf_q;
        assign negOverflow = neg_ovf_q;
    end else begin : gen_comb_out
        // Clock and reset have no function in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign S           = sum_d;
        assign Cout        = cout_d;
        assign posOverflow = pos_ovf_d;
        assign negOverflow = neg_ovf_d;
    end

endmodule : ripple_carry_adder

// File: tb/tb_ripple_carry_adder.sv
// Directed bench: combinational vector table plus registered-mode reset/latency sequences.
module tb_ripple_carry_adder;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         cout;
        logic         pos;
        logic         neg;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;

    logic [W-1:0] s_c;
    logic         cout_c;
    logic         pos_c;
    logic         neg_c;
    logic [W-1:0] s_r;
    logic         cout_r;
    logic         pos_r;
    logic         neg_r;

    int tests;
    int fails;

    ripple_carry_adder #(
        .WIDTH   (W),
        .REG_OUT (0)
    ) u_dut_comb (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .Cin         (cin),
        .S           (s_c),
        .Cout        (cout_c),
        .posOverflow (pos_c),
        .negOverflow (neg_c)
    );

    ripple_carry_adder #(
        .WIDTH   (W),
        .REG_OUT (1)
    ) u_dut_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .Cin         (cin),
        .S           (s_r),
        .Cout        (cout_r),
        .posOverflow (pos_r),
        .negOverflow (neg_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic [W-1:0] va, logic [W-1:0] vb, logic vc,
                                logic [W-1:0] vs, logic vco, logic vp, logic vn);
        vec_t v;
        v.a    = va;
        v.b    = vb;
        v.cin  = vc;
        v.s    = vs;
        v.cout = vco;
        v.pos  = vp;
        v.neg  = vn;
        return v;
    endfunction

    task automatic check(string name, logic [W-1:0] s_act, logic co_act, logic p_act,
                         logic n_act, logic [W-1:0] s_exp, logic co_exp, logic p_exp,
                         logic n_exp);
        tests++;
        if ({s_act, co_act, p_act, n_act} !== {s_exp, co_exp, p_exp, n_exp}) begin
            fails++;
            $display("FAIL %s: got S=%h Cout=%b pos=%b neg=%b, want S=%h Cout=%b pos=%b neg=%b",
                     name, s_act, co_act, p_act, n_act, s_exp, co_exp, p_exp, n_exp);
        end
    endtask

    vec_t vecs[12];

    initial begin
        tests = 0;
        fails = 0;

        vecs[0]  = mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        vecs[1]  = mk(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);
        vecs[2]  = mk(32'd5, 32'hFFFF_FFFD, 1'b0, 32'd2, 1'b1, 1'b0, 1'b0);
        vecs[3]  = mk(32'd8, 32'd7, 1'b0, 32'd15, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(32'hFFFF_FFF6, 32'hFFFF_FFF8, 1'b0, 32'hFFFF_FFEE, 1'b1, 1'b0, 1'b0);
        vecs[5]  = mk(32'hFFFF_FFE2, 32'd40, 1'b1, 32'd11, 1'b1, 1'b0, 1'b0);
        vecs[6]  = mk(32'd0, 32'd0, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(32'd100, 32'd50, 1'b1, 32'd151, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(32'h7FFF_FFFF, 32'd0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        vecs[9]  = mk(32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        vecs[10] = mk(32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        vecs[11] = mk(32'h4000_0000, 32'h4000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

        rst_n = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;

        // Combinational build, reset held low throughout to show it is ignored.
        for (int i = 0; i < 12; i++) begin
            a   = vecs[i].a;
            b   = vecs[i].b;
            cin = vecs[i].cin;
            #5;
            check($sformatf("comb_vec%0d", i), s_c, cout_c, pos_c, neg_c,
                  vecs[i].s, vecs[i].cout, vecs[i].pos, vecs[i].neg);
        end

        // Registered build: reset holds outputs at zero across clock edges.
        @(negedge clk);
        a   = 32'h7FFF_FFFF;
        b   = 32'd1;
        cin = 1'b0;
        @(posedge clk);
        #1;
        check("reg_in_reset", s_r, cout_r, pos_r, neg_r, '0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        a     = 32'd8;
        b     = 32'd7;
        #1;
        check("reg_before_edge", s_r, cout_r, pos_r, neg_r, '0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reg_8_plus_7", s_r, cout_r, pos_r, neg_r, 32'd15, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        a = 32'h7FFF_FFFF;
        b = 32'd1;
        #1;
        check("reg_holds_mid_cycle", s_r, cout_r, pos_r, neg_r, 32'd15, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reg_pos_ovf", s_r, cout_r, pos_r, neg_r, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

        @(negedge clk);
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        check("reg_neg_ovf", s_r, cout_r, pos_r, neg_r, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);

        // Asynchronous clear between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("reg_async_clear", s_r, cout_r, pos_r, neg_r, '0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reg_clear_held", s_r, cout_r, pos_r, neg_r, '0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_ripple_carry_adder
